dmem_responder: RTL and testbench

- Shared data-memory responder: the memory-side end of each core's data interface (address, read strobe, write strobe, write data, read data).
- Serves NUM_CORES cores in parallel. Reads are multi-ported with 1-cycle registered latency. Simultaneous writes are resolved by fixed priority.
- A host port loads the matrices before a run and dumps the results afterwards.
- A small FSM sequences IDLE/RUN/DONE and drives START to the cores.

---
 rtl/dmem_responder_if.sv | 38 +++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Bus bundle between the cores/host and the shared data-memory responder.
// The slave modport is the memory side; the master modport is the core/host side.
interface dmem_responder_if #(
   parameter int NUM_CORES = 2
);
   logic [NUM_CORES*16-1:0] core_addr;
   logic [NUM_CORES-1:0]    core_rd;
   logic [NUM_CORES-1:0]    core_wr;
   logic [NUM_CORES*16-1:0] core_wdata;
   logic [NUM_CORES*16-1:0] core_rdata;
   logic [NUM_CORES-1:0]    core_end;
   logic [15:0]             host_addr;
   logic                    host_we;
   logic                    host_re;
   logic [15:0]             host_wdata;
   logic [15:0]             host_rdata;
   logic                    host_rvalid;
   logic                    host_start;
   logic                    host_clear;
   logic                    start_cores;
   logic                    done;
   logic [15:0]             conflict_cnt;
   logic                    range_err;

   modport slave (
      input  core_addr, core_rd, core_wr, core_wdata, core_end,
      input  host_addr, host_we, host_re, host_wdata, host_start, host_clear,
      output core_rdata, host_rdata, host_rvalid, start_cores, done,
      output conflict_cnt, range_err
   );

   modport master (
      output core_addr, core_rd, core_wr, core_wdata, core_end,
      output host_addr, host_we, host_re, host_wdata, host_start, host_clear,
      input  core_rdata, host_rdata, host_rvalid, start_cores, done,
      input  conflict_cnt, range_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Shared data-memory responder: multi-ported 1-cycle reads for NUM_CORES cores,
// fixed-priority single write per cycle, host load/dump port, IDLE/RUN/DONE sequencer.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | host port owns memory, waiting for host_start
// S_RUN  | start_cores high, core ports own memory, host ignored
// S_DONE | all cores ended, done high, host may dump or restart
module dmem_responder #(
   parameter int NUM_CORES = 2,
   parameter int ADDR_W    = 8,
   parameter int DW        = 16
) (
   input logic             clk,
   input logic             RESET,
   dmem_responder_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                   r_state;
   logic [DW-1:0]            r_mem [DEPTH];
   logic [NUM_CORES*DW-1:0]  r_core_rdata;
   logic [DW-1:0]            r_host_rdata;
   logic                     r_host_rvalid;
   logic                     r_start_cores;
   logic                     r_done;
   logic [15:0]              r_conflict_cnt;
   logic                     r_range_err;

   logic                     w_run;
   logic                     w_host_act;
   logic                     w_host_in_range;
   logic                     w_host_oor;
   logic                     w_core_oor;
   logic                     w_conflict;
   logic                     w_wr_en;
   logic [ADDR_W-1:0]        w_wr_addr;
   logic [DW-1:0]            w_wr_data;

   // Upper address bits beyond the implemented depth must be zero.
   function automatic logic f_in_range(input logic [15:0] a);
      return (a >> ADDR_W) == 16'd0;
   endfunction

   assign w_run           = (r_state == S_RUN);
   assign w_host_act      = !w_run;
   assign w_host_in_range = f_in_range(bus.host_addr);
   assign w_host_oor      = w_host_act && (bus.host_we || bus.host_re) && !w_host_in_range;
   assign w_conflict      = w_run && ($countones(bus.core_wr) > 1);

   // Pick the single memory write for this cycle: lowest in-range core in RUN, else host.
   always_comb begin
      w_wr_en    = 1'b0;
      w_wr_addr  = '0;
      w_wr_data  = '0;
      w_core_oor = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (w_run && (bus.core_rd[k] || bus.core_wr[k]) && !f_in_range(bus.core_addr[16*k +: 16]))
            w_core_oor = 1'b1;
         // An out-of-range higher-priority writer must not block a lower one.
         if (w_run && bus.core_wr[k] && f_in_range(bus.core_addr[16*k +: 16]) && !w_wr_en) begin
            w_wr_en   = 1'b1;
            w_wr_addr = bus.core_addr[16*k +: ADDR_W];
            w_wr_data = bus.core_wdata[16*k +: DW];
         end
      end
      if (w_host_act && bus.host_we && w_host_in_range) begin
         w_wr_en   = 1'b1;
         w_wr_addr = bus.host_addr[ADDR_W-1:0];
         w_wr_data = bus.host_wdata;
      end
   end

   // Memory array; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[w_wr_addr] <= w_wr_data;
   end

   // Per-core registered read data; reads see pre-write contents of the same edge.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_core_rdata <= '0;
      end else begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (w_run && bus.core_rd[k]) begin
               if (f_in_range(bus.core_addr[16*k +: 16]))
                  r_core_rdata[16*k +: DW] <= r_mem[bus.core_addr[16*k +: ADDR_W]];
               else
                  r_core_rdata[16*k +: DW] <= '0;
            end
         end
      end
   end

   // Host registered read data and one-cycle valid pulse.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_host_rdata  <= '0;
         r_host_rvalid <= 1'b0;
      end else begin
         r_host_rvalid <= w_host_act && bus.host_re;
         if (w_host_act && bus.host_re)
            r_host_rdata <= w_host_in_range ? r_mem[bus.host_addr[ADDR_W-1:0]] : '0;
      end
   end

   // Saturating write-conflict counter and sticky range error.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_conflict_cnt <= '0;
         r_range_err    <= 1'b0;
      end else begin
         if (w_conflict && (r_conflict_cnt != 16'hFFFF))
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
         if (w_core_oor || w_host_oor)
            r_range_err <= 1'b1;
      end
   end

   // Run sequencer with registered start_cores/done; host_start wins over host_clear in DONE.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         r_state       <= S_IDLE;
         r_start_cores <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.host_start) begin
                  r_state       <= S_RUN;
                  r_start_cores <= 1'b1;
               end
            end
            S_RUN: begin
               if (&bus.core_end) begin
                  r_state       <= S_DONE;
                  r_start_cores <= 1'b0;
                  r_done        <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.host_start) begin
                  r_state       <= S_RUN;
                  r_start_cores <= 1'b1;
                  r_done        <= 1'b0;
               end else if (bus.host_clear) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_start_cores <= 1'b0;
               r_done        <= 1'b0;
            end
         endcase
      end
   end

   assign bus.core_rdata   = r_core_rdata;
   assign bus.host_rdata   = r_host_rdata;
   assign bus.host_rvalid  = r_host_rvalid;
   assign bus.start_cores  = r_start_cores;
   assign bus.done         = r_done;
   assign bus.conflict_cnt = r_conflict_cnt;
   assign bus.range_err    = r_range_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized core/host traffic,
// checked every cycle against a word-array reference model of the memory and run phases.
module tb_dmem_responder;
   localparam int NC = 2;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic RESET;
   always #5 clk = ~clk;

   dmem_responder_if #(.NUM_CORES(NC)) bus();

   dmem_responder #(.NUM_CORES(NC), .ADDR_W(AW), .DW(16)) dut (
      .clk   (clk),
      .RESET (RESET),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 = idle, 1 = run, 2 = done
   logic [15:0]      m_mem [256];
   int               m_phase;
   logic [15:0]      m_crd [NC];
   logic [15:0]      m_hrd;
   logic             m_rv;
   int               m_conf;
   logic             m_rerr;
   int               m_wk;
   logic [15:0]      m_a;
   logic [15:0]      m_wd;
   logic [NC*16-1:0] m_crd_vec;

   always @(posedge clk or posedge RESET) begin
      if (RESET) begin
         m_phase = 0;
         for (int k = 0; k < NC; k++) m_crd[k] = 16'h0;
         m_hrd  = 16'h0;
         m_rv   = 1'b0;
         m_conf = 0;
         m_rerr = 1'b0;
      end else begin
         if (m_phase == 1) begin
            m_wk = -1;
            m_wd = 16'h0;
            m_a  = 16'h0;
            for (int k = 0; k < NC; k++) begin
               if ((bus.core_rd[k] || bus.core_wr[k]) && bus.core_addr[16*k +: 16] >= 16'd256)
                  m_rerr = 1'b1;
               if (bus.core_rd[k])
                  m_crd[k] = (bus.core_addr[16*k +: 16] < 16'd256) ? m_mem[bus.core_addr[16*k +: 8]] : 16'h0;
               if (bus.core_wr[k] && bus.core_addr[16*k +: 16] < 16'd256 && m_wk < 0) begin
                  m_wk = k;
                  m_a  = bus.core_addr[16*k +: 16];
                  m_wd = bus.core_wdata[16*k +: 16];
               end
            end
            if ($countones(bus.core_wr) >= 2 && m_conf < 65535) m_conf++;
            if (m_wk >= 0) m_mem[m_a[7:0]] = m_wd;
            m_rv = 1'b0;
         end else begin
            m_a = bus.host_addr;
            if ((bus.host_we || bus.host_re) && m_a >= 16'd256) m_rerr = 1'b1;
            m_rv = bus.host_re;
            if (bus.host_re) m_hrd = (m_a < 16'd256) ? m_mem[m_a[7:0]] : 16'h0;
            if (bus.host_we && m_a < 16'd256) m_mem[m_a[7:0]] = bus.host_wdata;
         end
         case (m_phase)
            0: if (bus.host_start) m_phase = 1;
            1: if (&bus.core_end) m_phase = 2;
            default: begin
               if (bus.host_start) m_phase = 1;
               else if (bus.host_clear) m_phase = 0;
            end
         endcase
      end
   end

   // Compare all outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         for (int k = 0; k < NC; k++) m_crd_vec[16*k +: 16] = m_crd[k];
         check("core_rdata",   32'(bus.core_rdata),   32'(m_crd_vec));
         check("host_rvalid",  32'(bus.host_rvalid),  32'(m_rv));
         if (m_rv) check("host_rdata", 32'(bus.host_rdata), 32'(m_hrd));
         check("start_cores",  32'(bus.start_cores),  32'(m_phase == 1));
         check("done",         32'(bus.done),         32'(m_phase == 2));
         check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_conf));
         check("range_err",    32'(bus.range_err),    32'(m_rerr));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.core_addr  = '0;
      bus.core_rd    = '0;
      bus.core_wr    = '0;
      bus.core_wdata = '0;
      bus.core_end   = '0;
      bus.host_addr  = '0;
      bus.host_we    = 1'b0;
      bus.host_re    = 1'b0;
      bus.host_wdata = '0;
      bus.host_start = 1'b0;
      bus.host_clear = 1'b0;
   endtask

   task automatic host_wr(input logic [15:0] a, input logic [15:0] d);
      bus.host_addr  = a;
      bus.host_wdata = d;
      bus.host_we    = 1'b1;
      tick();
      bus.host_we    = 1'b0;
   endtask

   task automatic host_rd(input logic [15:0] a);
      bus.host_addr = a;
      bus.host_re   = 1'b1;
      tick();
      bus.host_re   = 1'b0;
   endtask

   function automatic logic [15:0] rand_addr();
      if ($urandom_range(0, 15) == 0) return 16'h0100 | 16'($urandom_range(0, 255));
      return 16'($urandom_range(0, 15));
   endfunction

   task automatic random_run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < NC; k++) begin
            bus.core_addr[16*k +: 16]  = rand_addr();
            bus.core_wdata[16*k +: 16] = 16'($urandom);
         end
         bus.core_rd    = NC'($urandom);
         bus.core_wr    = NC'($urandom);
         bus.core_end   = NC'($urandom) & NC'(1);
         bus.host_addr  = 16'($urandom_range(0, 15));
         bus.host_we    = 1'($urandom);
         bus.host_re    = 1'($urandom);
         bus.host_wdata = 16'($urandom);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      RESET = 1'b1;
      idle_inputs();
      tick();
      tick();
      check("rst_core_rdata",  32'(bus.core_rdata),   32'h0);
      check("rst_start_cores", 32'(bus.start_cores),  32'h0);
      check("rst_done",        32'(bus.done),         32'h0);
      check("rst_conflict",    32'(bus.conflict_cnt), 32'h0);
      check("rst_range_err",   32'(bus.range_err),    32'h0);
      check("rst_rvalid",      32'(bus.host_rvalid),  32'h0);
      RESET = 1'b0;
      cmp_en = 1'b1;

      // Preload the whole memory so every later read has a known expectation.
      for (int i = 0; i < 256; i++) host_wr(16'(i), 16'($urandom));
      host_wr(16'h0080, 16'hBEEF);

      // Host load/read with same-cycle old-data behaviour exercised afterwards.
      host_wr(16'h0005, 16'h1234);
      host_rd(16'h0005);
      check("host_rd_data",  32'(bus.host_rdata),  32'h1234);
      check("host_rd_valid", 32'(bus.host_rvalid), 32'h1);
      tick();
      check("host_rvalid_drop", 32'(bus.host_rvalid), 32'h0);
      bus.host_addr = 16'h0005; bus.host_wdata = 16'h4321;
      bus.host_we = 1'b1; bus.host_re = 1'b1;
      tick();
      bus.host_we = 1'b0; bus.host_re = 1'b0;
      check("host_rw_old", 32'(bus.host_rdata), 32'h1234);

      // Parallel reads.
      host_wr(16'h0003, 16'h00AA);
      host_wr(16'h0007, 16'h00BB);
      bus.host_start = 1'b1;
      tick();
      bus.host_start = 1'b0;
      check("start_cores_run", 32'(bus.start_cores), 32'h1);
      bus.core_addr = {16'h0007, 16'h0003};
      bus.core_rd   = 2'b11;
      tick();
      bus.core_rd   = 2'b00;
      check("par_reads", 32'(bus.core_rdata), 32'h00BB_00AA);

      // Write conflict for three cycles at the same address.
      bus.core_addr  = {16'h0009, 16'h0009};
      bus.core_wdata = {16'h2222, 16'h1111};
      bus.core_wr    = 2'b11;
      tick();
      check("conflict_1", 32'(bus.conflict_cnt), 32'd1);
      tick();
      tick();
      bus.core_wr = 2'b00;
      check("conflict_3", 32'(bus.conflict_cnt), 32'd3);
      bus.core_rd = 2'b01;
      tick();
      bus.core_rd = 2'b00;
      check("conflict_winner", 32'(bus.core_rdata[15:0]), 32'h1111);

      // Out-of-range write by core1, then out-of-range read by core0.
      check("range_err_clear", 32'(bus.range_err), 32'h0);
      bus.core_addr  = {16'h0100, 16'h0000};
      bus.core_wdata = {16'h5555, 16'h0000};
      bus.core_wr    = 2'b10;
      tick();
      bus.core_wr = 2'b00;
      check("range_err_set", 32'(bus.range_err), 32'h1);
      bus.core_addr = {16'h0000, 16'h0100};
      bus.core_rd   = 2'b01;
      tick();
      bus.core_rd   = 2'b00;
      check("oor_read_zero", 32'(bus.core_rdata[15:0]), 32'h0);
      check("range_err_sticky", 32'(bus.range_err), 32'h1);

      // Randomized core traffic (host strobes must be ignored).
      random_run_cycles(300);

      // Completion.
      bus.core_end = 2'b01;
      tick();
      check("partial_end_run",  32'(bus.start_cores), 32'h1);
      check("partial_end_done", 32'(bus.done),        32'h0);
      bus.core_end = 2'b11;
      tick();
      bus.core_end = 2'b00;
      check("done_set",   32'(bus.done),        32'h1);
      check("start_drop", 32'(bus.start_cores), 32'h0);
      for (int i = 0; i < 40; i++) begin
         bus.host_addr  = ($urandom_range(0, 7) == 0) ? 16'h0200 : 16'($urandom_range(0, 15));
         bus.host_re    = 1'($urandom);
         bus.host_we    = 1'($urandom);
         bus.host_wdata = 16'($urandom);
         tick();
      end
      idle_inputs();
      bus.host_clear = 1'b1;
      tick();
      bus.host_clear = 1'b0;
      check("clear_done", 32'(bus.done), 32'h0);
      tick();

      // Second run: DONE with start and clear together restarts.
      bus.host_start = 1'b1;
      tick();
      bus.host_start = 1'b0;
      random_run_cycles(100);
      bus.core_end = 2'b11;
      tick();
      bus.core_end = 2'b00;
      bus.host_start = 1'b1;
      bus.host_clear = 1'b1;
      tick();
      idle_inputs();
      check("restart_prio_start", 32'(bus.start_cores), 32'h1);
      check("restart_prio_done",  32'(bus.done),        32'h0);
      random_run_cycles(50);

      // Asynchronous reset mid-run.
      bus.core_addr = {16'h0001, 16'h0001};
      bus.core_wr   = 2'b11;
      tick();
      bus.core_wr   = 2'b00;
      #2 RESET = 1'b1;
      #1;
      check("arst_start", 32'(bus.start_cores),  32'h0);
      check("arst_done",  32'(bus.done),         32'h0);
      check("arst_conf",  32'(bus.conflict_cnt), 32'h0);
      tick();
      RESET = 1'b0;
      host_rd(16'h0080);
      check("post_rst_preload", 32'(bus.host_rdata), 32'hBEEF);
      tick();
      tick();

      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
